// File: rtl/line_buffer_3row_if.sv
// Pixel stream in / three-row window out for line_buffer_3row.
interface line_buffer_3row_if #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned COL_W = 9,
  parameter int unsigned ROW_W = 9
);
  logic             valid_in;
  logic [WIDTH-1:0] din;
  logic             valid_out;
  logic [WIDTH-1:0] dout1;
  logic [WIDTH-1:0] dout2;
  logic [WIDTH-1:0] dout3;
  logic [COL_W-1:0] out_col;
  logic [ROW_W-1:0] out_row;
  logic             eof_out;

  modport master (
    output valid_in, din,
    input  valid_out, dout1, dout2, dout3, out_col, out_row, eof_out
  );

  modport slave (
    input  valid_in, din,
    output valid_out, dout1, dout2, dout3, out_col, out_row, eof_out
  );
endinterface

// File: rtl/line_buffer_3row.sv
// Two-line buffer producing vertically aligned top/middle/bottom taps from a raster stream.
// Optional LB_BORDER_REPLICATE_EN: emit rows 0 and 1 with missing rows replicated.
module line_buffer_3row #(
  parameter int unsigned WIDTH      = 24,
  parameter int unsigned PIC_WIDTH  = 480,
  parameter int unsigned PIC_HEIGHT = 272,
  parameter int unsigned COL_W      = 9,
  parameter int unsigned ROW_W      = 9
) (
  input logic               clk,
  input logic               rst_n,
  line_buffer_3row_if.slave lb
);

  localparam int unsigned AW = (PIC_WIDTH > 1) ? $clog2(PIC_WIDTH) : 1;

  // Line memories are never reset; rows 0 and 1 gating hides their stale content.
  logic [WIDTH-1:0] ram_a [PIC_WIDTH];
  logic [WIDTH-1:0] ram_b [PIC_WIDTH];

  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic [WIDTH-1:0] top_d, mid_d;
  logic             col_last, row_last, row_ge2;
  logic             valid_d, eof_d;

  logic             valid_q, eof_q;
  logic [WIDTH-1:0] dout1_q, dout2_q, dout3_q;
  logic [COL_W-1:0] out_col_q;
  logic [ROW_W-1:0] out_row_q;

  assign addr     = col_cnt_q[AW-1:0];
  assign rd_a     = ram_a[addr];
  assign rd_b     = ram_b[addr];
  assign col_last = (col_cnt_q == COL_W'(PIC_WIDTH - 1));
  assign row_last = (row_cnt_q == ROW_W'(PIC_HEIGHT - 1));
  assign row_ge2  = (row_cnt_q >= ROW_W'(2));

  always_comb begin
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    if (lb.valid_in) begin
      if (col_last) begin
        col_cnt_d = '0;
        row_cnt_d = row_last ? '0 : row_cnt_q + 1'b1;
      end else begin
        col_cnt_d = col_cnt_q + 1'b1;
      end
    end
  end

`ifdef LB_BORDER_REPLICATE_EN
  always_comb begin
    mid_d = rd_a;
    top_d = rd_b;
    if (row_cnt_q == '0) begin
      mid_d = lb.din;
      top_d = lb.din;
    end else if (row_cnt_q == ROW_W'(1)) begin
      top_d = rd_a;
    end
  end

  assign valid_d = lb.valid_in;
  assign eof_d   = lb.valid_in && col_last && row_last;
`else
  assign mid_d   = rd_a;
  assign top_d   = rd_b;
  assign valid_d = lb.valid_in && row_ge2;
  assign eof_d   = lb.valid_in && col_last && row_last && row_ge2;
`endif

  // Read-before-write: the taps above already captured the old contents.
  always_ff @(posedge clk) begin
    if (lb.valid_in) begin
      ram_b[addr] <= rd_a;
      ram_a[addr] <= lb.din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      valid_q   <= 1'b0;
      eof_q     <= 1'b0;
      dout1_q   <= '0;
      dout2_q   <= '0;
      dout3_q   <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
    end else begin
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      valid_q   <= valid_d;
      eof_q     <= eof_d;
      if (lb.valid_in) begin
        dout1_q   <= top_d;
        dout2_q   <= mid_d;
        dout3_q   <= lb.din;
        out_col_q <= col_cnt_q;
        out_row_q <= row_cnt_q;
      end
    end
  end

  assign lb.valid_out = valid_q;
  assign lb.eof_out   = eof_q;
  assign lb.dout1     = dout1_q;
  assign lb.dout2     = dout2_q;
  assign lb.dout3     = dout3_q;
  assign lb.out_col   = out_col_q;
  assign lb.out_row   = out_row_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Self-checking bench for line_buffer_3row on a 4x4 picture against an image-array model.
module tb_line_buffer_3row;
  localparam int unsigned W  = 24;
  localparam int unsigned PW = 4;
  localparam int unsigned PH = 4;
  localparam int unsigned CW = 9;
  localparam int unsigned RW = 9;
`ifdef LB_BORDER_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_buffer_3row_if #(.WIDTH(W), .COL_W(CW), .ROW_W(RW)) lb_if ();

  line_buffer_3row #(
    .WIDTH(W), .PIC_WIDTH(PW), .PIC_HEIGHT(PH), .COL_W(CW), .ROW_W(RW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .lb   (lb_if)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: the picture as a 2-D array indexed by raster position.
  logic [W-1:0] img [PH][PW];
  int           m_row, m_col;
  logic         e_valid, e_eof, e_known;
  logic [W-1:0] e_d1, e_d2, e_d3;
  int           e_col, e_row;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0;
    e_valid = 1'b0; e_eof = 1'b0; e_known = 1'b1;
    e_d1 = '0; e_d2 = '0; e_d3 = '0; e_col = 0; e_row = 0;
  endtask

  task automatic model_accept(input logic [W-1:0] d);
    int r, c;
    r = m_row; c = m_col;
    img[r][c] = d;
    e_valid = (r >= 2) || REPL;
    e_known = e_valid;
    e_d3 = d;
    if (r >= 2) begin
      e_d1 = img[r-2][c];
      e_d2 = img[r-1][c];
    end else if (r == 1) begin
      e_d1 = img[0][c];
      e_d2 = img[0][c];
    end else begin
      e_d1 = d;
      e_d2 = d;
    end
    e_col = c; e_row = r;
    e_eof = e_valid && (c == PW - 1) && (r == PH - 1);
    if (c == PW - 1) begin
      m_col = 0;
      m_row = (r == PH - 1) ? 0 : r + 1;
    end else begin
      m_col = c + 1;
    end
  endtask

  task automatic check_outputs();
    check("valid_out", 32'(lb_if.valid_out), 32'(e_valid));
    check("eof_out",   32'(lb_if.eof_out),   32'(e_eof));
    check("out_col",   32'(lb_if.out_col),   32'(e_col));
    check("out_row",   32'(lb_if.out_row),   32'(e_row));
    if (e_known) begin
      check("dout1", 32'(lb_if.dout1), 32'(e_d1));
      check("dout2", 32'(lb_if.dout2), 32'(e_d2));
      check("dout3", 32'(lb_if.dout3), 32'(e_d3));
    end
  endtask

  // Called at a negedge; returns at the following negedge after checking.
  task automatic step(input logic v, input logic [W-1:0] d);
    lb_if.valid_in = v;
    lb_if.din      = d;
    @(posedge clk);
    if (v) model_accept(d);
    else begin
      e_valid = 1'b0;
      e_eof   = 1'b0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic do_reset();
    lb_if.valid_in = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(lb_if.valid_out), 32'd0);
    check("rst_eof",   32'(lb_if.eof_out),   32'd0);
    check("rst_dout1", 32'(lb_if.dout1),     32'd0);
    check("rst_dout2", 32'(lb_if.dout2),     32'd0);
    check("rst_dout3", 32'(lb_if.dout3),     32'd0);
    check("rst_col",   32'(lb_if.out_col),   32'd0);
    check("rst_row",   32'(lb_if.out_row),   32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode 0: continuous, 1: toggle + 7-cycle gap after row 2, 2: random gaps.
  // rnd: random pixel data; stop_after: number of pixels to send (PW*PH for a full frame).
  task automatic send_frame(input logic [W-1:0] base, input int mode, input bit rnd,
                            input int stop_after);
    logic [W-1:0] pix;
    int n;
    n = 0;
    for (int r = 0; r < int'(PH); r++) begin
      for (int c = 0; c < int'(PW); c++) begin
        if (n >= stop_after) return;
        pix = rnd ? W'($urandom) : base + W'(r * 16 + c);
        step(1'b1, pix);
        n++;
        if (!rnd && r == 2 && c == 0) begin
          check("spot20_valid", 32'(lb_if.valid_out), 32'd1);
          check("spot20_dout1", 32'(lb_if.dout1), 32'(base));
          check("spot20_dout2", 32'(lb_if.dout2), 32'(base + 24'h10));
          check("spot20_dout3", 32'(lb_if.dout3), 32'(base + 24'h20));
        end
        if (!rnd && r == 3 && c == 3) begin
          check("spot33_eof",   32'(lb_if.eof_out), 32'd1);
          check("spot33_dout1", 32'(lb_if.dout1), 32'(base + 24'h13));
          check("spot33_dout2", 32'(lb_if.dout2), 32'(base + 24'h23));
        end
`ifdef LB_BORDER_REPLICATE_EN
        if (!rnd && r == 0 && c == 0) check("repl00_dout1", 32'(lb_if.dout1), 32'(base));
        if (!rnd && r == 1 && c == 1) check("repl11_dout1", 32'(lb_if.dout1), 32'(base + 24'h01));
        if (!rnd && r == 2 && c == 2) check("repl22_dout2", 32'(lb_if.dout2), 32'(base + 24'h12));
`endif
        if (mode == 1) begin
          step(1'b0, '0);
          if (r == 2 && c == int'(PW) - 1) idle(7);
        end else if (mode == 2) begin
          idle(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
        end
      end
    end
  endtask

  initial begin
    lb_if.valid_in = 1'b0;
    lb_if.din      = '0;
    model_reset();
    #12 rst_n = 1'b1;
    @(negedge clk);

    // Async reset mid-clock, then idle.
    do_reset();
    idle(5);

    // Continuous frame, then toggled frame with a row gap.
    send_frame(24'h0, 0, 1'b0, PW * PH);
    send_frame(24'h0, 1, 1'b0, PW * PH);

    // Back-to-back frames, the second offset by 0x80.
    send_frame(24'h0, 0, 1'b0, PW * PH);
    send_frame(24'h80, 0, 1'b0, PW * PH);

    // Reset after pixel 0x21, then restart a frame.
    send_frame(24'h0, 0, 1'b0, 2 * PW + 2);
    do_reset();
    send_frame(24'h0, 0, 1'b0, PW * PH);

    // Random data with random gaps, including a reset mid-frame.
    for (int f = 0; f < 4; f++) send_frame('0, 2, 1'b1, PW * PH);
    send_frame('0, 2, 1'b1, int'($urandom_range(1, PW * PH - 1)));
    do_reset();
    for (int f = 0; f < 3; f++) send_frame('0, 2, 1'b1, PW * PH);
    idle(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
